// File: rtl/reservation_station.sv
// Tomasulo reservation station: tagged entry allocation, CDB operand snooping,
// and in-order-by-index dispatch to one functional unit over valid/ready.
module reservation_station #(
  parameter int unsigned ENTRIES  = 3,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned TAG_W    = 4,
  parameter int unsigned TAG_BASE = 1
) (
  input  logic              clk,
  input  logic              nRST,
  input  logic              issueEN,
  input  logic [1:0]        ALUop,
  input  logic [DATA_W-1:0] Vj,
  input  logic [DATA_W-1:0] Vk,
  input  logic [TAG_W-1:0]  Qj,
  input  logic [TAG_W-1:0]  Qk,
  output logic [TAG_W-1:0]  issueTag,
  output logic              isFull,
  input  logic              CDBValid,
  input  logic [TAG_W-1:0]  CDBTag,
  input  logic [DATA_W-1:0] CDBData,
  output logic              dispValid,
  input  logic              aluReady,
  output logic [1:0]        dispOp,
  output logic [DATA_W-1:0] dispA,
  output logic [DATA_W-1:0] dispB,
  output logic [TAG_W-1:0]  dispTag
);

  localparam int unsigned IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

  typedef enum logic {LK_FREE, LK_HELD} lock_t;

  logic [ENTRIES-1:0] busy_q, busy_d;
  logic [1:0]         op_q [ENTRIES];
  logic [1:0]         op_d [ENTRIES];
  logic [DATA_W-1:0]  vj_q [ENTRIES];
  logic [DATA_W-1:0]  vj_d [ENTRIES];
  logic [DATA_W-1:0]  vk_q [ENTRIES];
  logic [DATA_W-1:0]  vk_d [ENTRIES];
  logic [TAG_W-1:0]   qj_q [ENTRIES];
  logic [TAG_W-1:0]   qj_d [ENTRIES];
  logic [TAG_W-1:0]   qk_q [ENTRIES];
  logic [TAG_W-1:0]   qk_d [ENTRIES];
  lock_t              lock_q, lock_d;
  logic [IDX_W-1:0]   lock_idx_q, lock_idx_d;

  logic [IDX_W-1:0]   free_idx, rdy_idx, sel_idx;
  logic               free_found, rdy_found;
  logic [ENTRIES-1:0] ready;
  logic               accept, issue_ok, cdb_live;

  function automatic logic [TAG_W-1:0] tag_of(input logic [IDX_W-1:0] idx);
    return TAG_W'(TAG_BASE) + TAG_W'(idx);
  endfunction

  // Allocation and ready priority encoders, both lowest-index first.
  always_comb begin
    free_idx   = '0;
    free_found = 1'b0;
    rdy_idx    = '0;
    rdy_found  = 1'b0;
    for (int unsigned i = 0; i < ENTRIES; i++) begin
      ready[i] = busy_q[i] && (qj_q[i] == '0) && (qk_q[i] == '0);
      if (!busy_q[i] && !free_found) begin
        free_idx   = IDX_W'(i);
        free_found = 1'b1;
      end
      if (ready[i] && !rdy_found) begin
        rdy_idx   = IDX_W'(i);
        rdy_found = 1'b1;
      end
    end
  end

  always_comb begin
    isFull    = ~free_found;
    issueTag  = tag_of(free_idx);
    sel_idx   = (lock_q == LK_HELD) ? lock_idx_q : rdy_idx;
    dispValid = (lock_q == LK_HELD) || rdy_found;
    dispOp    = '0;
    dispA     = '0;
    dispB     = '0;
    dispTag   = '0;
    if (dispValid) begin
      dispOp  = op_q[sel_idx];
      dispA   = vj_q[sel_idx];
      dispB   = vk_q[sel_idx];
      dispTag = tag_of(sel_idx);
    end
  end

  assign accept   = dispValid && aluReady;
  assign issue_ok = issueEN && !isFull;
  assign cdb_live = CDBValid && (CDBTag != '0);

  // Issue only ever targets a non-busy slot while dispatch and wakeup touch
  // busy ones, so the three updates never collide on the same entry.
  always_comb begin
    busy_d     = busy_q;
    op_d       = op_q;
    vj_d       = vj_q;
    vk_d       = vk_q;
    qj_d       = qj_q;
    qk_d       = qk_q;
    lock_d     = lock_q;
    lock_idx_d = lock_idx_q;

    for (int unsigned i = 0; i < ENTRIES; i++) begin
      if (busy_q[i] && cdb_live && (qj_q[i] == CDBTag)) begin
        vj_d[i] = CDBData;
        qj_d[i] = '0;
      end
      if (busy_q[i] && cdb_live && (qk_q[i] == CDBTag)) begin
        vk_d[i] = CDBData;
        qk_d[i] = '0;
      end
    end

    if (accept) begin
      busy_d[sel_idx] = 1'b0;
      lock_d          = LK_FREE;
    end else if (dispValid) begin
      lock_d     = LK_HELD;
      lock_idx_d = sel_idx;
    end

    if (issue_ok) begin
      busy_d[free_idx] = 1'b1;
      op_d[free_idx]   = ALUop;
      if (cdb_live && (Qj == CDBTag)) begin
        vj_d[free_idx] = CDBData;
        qj_d[free_idx] = '0;
      end else begin
        vj_d[free_idx] = Vj;
        qj_d[free_idx] = Qj;
      end
      if (cdb_live && (Qk == CDBTag)) begin
        vk_d[free_idx] = CDBData;
        qk_d[free_idx] = '0;
      end else begin
        vk_d[free_idx] = Vk;
        qk_d[free_idx] = Qk;
      end
    end
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      busy_q     <= '0;
      lock_q     <= LK_FREE;
      lock_idx_q <= '0;
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        op_q[i] <= '0;
        vj_q[i] <= '0;
        vk_q[i] <= '0;
        qj_q[i] <= '0;
        qk_q[i] <= '0;
      end
    end else begin
      busy_q     <= busy_d;
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
      op_q       <= op_d;
      vj_q       <= vj_d;
      vk_q       <= vk_d;
      qj_q       <= qj_d;
      qk_q       <= qk_d;
    end
  end

endmodule

// File: tb/tb_reservation_station.sv
// Directed bench for reservation_station (3 entries, tags 1..3).
module tb_reservation_station;

  logic        clk = 1'b0;
  logic        nRST;
  logic        issueEN;
  logic [1:0]  ALUop;
  logic [31:0] Vj, Vk;
  logic [3:0]  Qj, Qk;
  logic [3:0]  issueTag;
  logic        isFull;
  logic        CDBValid;
  logic [3:0]  CDBTag;
  logic [31:0] CDBData;
  logic        dispValid;
  logic        aluReady;
  logic [1:0]  dispOp;
  logic [31:0] dispA, dispB;
  logic [3:0]  dispTag;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  reservation_station #(
    .ENTRIES(3), .DATA_W(32), .TAG_W(4), .TAG_BASE(1)
  ) dut (
    .clk(clk), .nRST(nRST), .issueEN(issueEN), .ALUop(ALUop),
    .Vj(Vj), .Vk(Vk), .Qj(Qj), .Qk(Qk),
    .issueTag(issueTag), .isFull(isFull),
    .CDBValid(CDBValid), .CDBTag(CDBTag), .CDBData(CDBData),
    .dispValid(dispValid), .aluReady(aluReady), .dispOp(dispOp),
    .dispA(dispA), .dispB(dispB), .dispTag(dispTag)
  );

  always #5 clk = ~clk;

  task automatic idle();
    issueEN = 1'b0; ALUop = '0; Vj = '0; Vk = '0; Qj = '0; Qk = '0;
    CDBValid = 1'b0; CDBTag = '0; CDBData = '0; aluReady = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_issue(input logic [1:0] op, input logic [31:0] vj, input logic [3:0] qj,
                           input logic [31:0] vk, input logic [3:0] qk);
    issueEN = 1'b1; ALUop = op; Vj = vj; Qj = qj; Vk = vk; Qk = qk;
  endtask

  task automatic set_cdb(input logic [3:0] tag, input logic [31:0] data);
    CDBValid = 1'b1; CDBTag = tag; CDBData = data;
  endtask

  task automatic test_reset();
    idle();
    nRST = 1'b0;
    step();
    step();
    nRST = 1'b1;
    step();
    n_vec++; if (isFull !== 1'b0) begin n_err++; $display("FAIL rst_full: got %0h expected 0", isFull); end
    n_vec++; if (dispValid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %0h expected 0", dispValid); end
    n_vec++; if (issueTag !== 4'd1) begin n_err++; $display("FAIL rst_issueTag: got %0h expected 1", issueTag); end
    n_vec++; if ({dispOp, dispA, dispB, dispTag} !== '0) begin n_err++;
      $display("FAIL rst_disp: got op=%0h a=%0h b=%0h tag=%0h expected all 0", dispOp, dispA, dispB, dispTag); end
  endtask

  task automatic test_issue_dispatch();
    set_issue(2'd1, 32'd5, 4'd0, 32'd7, 4'd0);
    #1;
    n_vec++; if (dispValid !== 1'b0) begin n_err++; $display("FAIL iss_same_cycle: got %0h expected 0", dispValid); end
    step();
    idle();
    n_vec++; if (dispValid !== 1'b1) begin n_err++; $display("FAIL iss_valid: got %0h expected 1", dispValid); end
    n_vec++; if ({dispOp, dispA, dispB, dispTag} !== {2'd1, 32'd5, 32'd7, 4'd1}) begin n_err++;
      $display("FAIL iss_disp: got op=%0h a=%0h b=%0h tag=%0h expected 1/5/7/1", dispOp, dispA, dispB, dispTag); end
    n_vec++; if (issueTag !== 4'd2) begin n_err++; $display("FAIL iss_nextTag: got %0h expected 2", issueTag); end
    aluReady = 1'b1;
    step();
    idle();
    n_vec++; if (dispValid !== 1'b0) begin n_err++; $display("FAIL iss_freed_valid: got %0h expected 0", dispValid); end
    n_vec++; if (issueTag !== 4'd1) begin n_err++; $display("FAIL iss_freed_tag: got %0h expected 1", issueTag); end
  endtask

  task automatic test_wakeup();
    set_issue(2'd2, 32'd99, 4'd6, 32'd3, 4'd0);
    step();
    idle();
    n_vec++; if (dispValid !== 1'b0) begin n_err++; $display("FAIL wk_pending: got %0h expected 0", dispValid); end
    set_cdb(4'd5, 32'h55);
    step();
    idle();
    n_vec++; if (dispValid !== 1'b0) begin n_err++; $display("FAIL wk_wrong_tag: got %0h expected 0", dispValid); end
    set_cdb(4'd6, 32'h1234);
    step();
    idle();
    n_vec++; if (dispValid !== 1'b1) begin n_err++; $display("FAIL wk_valid: got %0h expected 1", dispValid); end
    n_vec++; if ({dispOp, dispA, dispB, dispTag} !== {2'd2, 32'h1234, 32'd3, 4'd1}) begin n_err++;
      $display("FAIL wk_disp: got op=%0h a=%0h b=%0h tag=%0h expected 2/1234/3/1", dispOp, dispA, dispB, dispTag); end
    aluReady = 1'b1;
    step();
    idle();
    n_vec++; if (dispValid !== 1'b0) begin n_err++; $display("FAIL wk_drain: got %0h expected 0", dispValid); end
  endtask

  task automatic test_full();
    set_issue(2'd0, 32'd0, 4'd7, 32'd11, 4'd0); step();
    set_issue(2'd0, 32'd0, 4'd7, 32'd22, 4'd0); step();
    set_issue(2'd0, 32'd0, 4'd8, 32'd33, 4'd0); step();
    idle();
    n_vec++; if (isFull !== 1'b1) begin n_err++; $display("FAIL full_set: got %0h expected 1", isFull); end
    set_issue(2'd3, 32'd40, 4'd0, 32'd44, 4'd0);
    step();
    idle();
    n_vec++; if ({isFull, dispValid} !== 2'b10) begin n_err++;
      $display("FAIL full_ignore: got full=%0h valid=%0h expected 1/0", isFull, dispValid); end
    set_cdb(4'd7, 32'h70);
    step();
    idle();
    n_vec++; if ({dispValid, dispTag, dispA, dispB} !== {1'b1, 4'd1, 32'h70, 32'd11}) begin n_err++;
      $display("FAIL full_wake: got v=%0h tag=%0h a=%0h b=%0h expected 1/1/70/b", dispValid, dispTag, dispA, dispB); end
    aluReady = 1'b1;
    set_issue(2'd3, 32'h5A, 4'd0, 32'h5B, 4'd0);
    step();
    idle();
    n_vec++; if ({isFull, issueTag} !== {1'b0, 4'd1}) begin n_err++;
      $display("FAIL full_fifth: got full=%0h issueTag=%0h expected 0/1", isFull, issueTag); end
    n_vec++; if ({dispTag, dispA, dispB} !== {4'd2, 32'h70, 32'd22}) begin n_err++;
      $display("FAIL full_second: got tag=%0h a=%0h b=%0h expected 2/70/16", dispTag, dispA, dispB); end
    aluReady = 1'b1;
    step();
    idle();
    n_vec++; if (dispValid !== 1'b0) begin n_err++; $display("FAIL full_third_wait: got %0h expected 0", dispValid); end
    set_cdb(4'd8, 32'h80);
    step();
    idle();
    n_vec++; if ({dispValid, dispTag, dispA, dispB} !== {1'b1, 4'd3, 32'h80, 32'd33}) begin n_err++;
      $display("FAIL full_third: got v=%0h tag=%0h a=%0h b=%0h expected 1/3/80/21", dispValid, dispTag, dispA, dispB); end
    aluReady = 1'b1;
    step();
    idle();
    n_vec++; if ({dispValid, issueTag} !== {1'b0, 4'd1}) begin n_err++;
      $display("FAIL full_empty: got v=%0h issueTag=%0h expected 0/1", dispValid, issueTag); end
  endtask

  task automatic test_bypass();
    set_issue(2'd2, 32'd4, 4'd0, 32'h99, 4'd9);
    set_cdb(4'd9, 32'hAB);
    step();
    idle();
    n_vec++; if ({dispValid, dispTag, dispA, dispB} !== {1'b1, 4'd1, 32'd4, 32'hAB}) begin n_err++;
      $display("FAIL byp_disp: got v=%0h tag=%0h a=%0h b=%0h expected 1/1/4/ab", dispValid, dispTag, dispA, dispB); end
    aluReady = 1'b1;
    step();
    idle();
  endtask

  task automatic test_back_to_back();
    set_issue(2'd1, 32'd1, 4'd0, 32'd2, 4'd0);
    step();
    set_issue(2'd2, 32'd3, 4'd0, 32'd4, 4'd0);
    aluReady = 1'b1;
    set_cdb(4'd12, 32'hFF);
    step();
    idle();
    n_vec++; if ({dispValid, dispTag, dispA, dispB, issueTag} !== {1'b1, 4'd2, 32'd3, 32'd4, 4'd1}) begin n_err++;
      $display("FAIL b2b: got v=%0h tag=%0h a=%0h b=%0h issueTag=%0h expected 1/2/3/4/1",
               dispValid, dispTag, dispA, dispB, issueTag); end
    aluReady = 1'b1;
    step();
    idle();
  endtask

  task automatic test_lock_and_reset();
    set_issue(2'd0, 32'd0, 4'd10, 32'd1, 4'd0); step();
    set_issue(2'd0, 32'd0, 4'd11, 32'd2, 4'd0); step();
    set_issue(2'd3, 32'h21, 4'd0, 32'h22, 4'd0); step();
    idle();
    n_vec++; if (dispTag !== 4'd3) begin n_err++; $display("FAIL lock_first: got %0h expected 3", dispTag); end
    set_cdb(4'd10, 32'h100);
    step();
    idle();
    n_vec++; if ({dispTag, dispA, dispOp} !== {4'd3, 32'h21, 2'd3}) begin n_err++;
      $display("FAIL lock_hold: got tag=%0h a=%0h op=%0h expected 3/21/3", dispTag, dispA, dispOp); end
    step();
    n_vec++; if (dispTag !== 4'd3) begin n_err++; $display("FAIL lock_hold2: got %0h expected 3", dispTag); end
    aluReady = 1'b1;
    step();
    idle();
    n_vec++; if ({dispValid, dispTag, dispA, dispB} !== {1'b1, 4'd1, 32'h100, 32'd1}) begin n_err++;
      $display("FAIL lock_next: got v=%0h tag=%0h a=%0h b=%0h expected 1/1/100/1", dispValid, dispTag, dispA, dispB); end
    nRST = 1'b0;
    #1;
    n_vec++; if ({dispValid, isFull, issueTag, dispTag} !== {1'b0, 1'b0, 4'd1, 4'd0}) begin n_err++;
      $display("FAIL rst_mid: got v=%0h full=%0h issueTag=%0h tag=%0h expected 0/0/1/0", dispValid, isFull, issueTag, dispTag); end
    step();
    nRST = 1'b1;
    set_cdb(4'd11, 32'h111);
    step();
    idle();
    n_vec++; if (dispValid !== 1'b0) begin n_err++; $display("FAIL rst_discard: got %0h expected 0", dispValid); end
  endtask

  initial begin
    test_reset();
    test_issue_dispatch();
    test_wakeup();
    test_full();
    test_bypass();
    test_back_to_back();
    test_lock_and_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/reservation_station.md
# reservation_station

Parameterised Tomasulo reservation station that sits directly downstream of the control unit. It accepts an issued instruction when its station-enable bit is asserted and allocates a tagged entry. It snoops the common data bus (CDB) for pending operands and dispatches ready entries to its functional unit over a valid/ready handshake. Its `isFull` output feeds the control unit's `isFull` input bit for this station, which stalls issue.

## Interface
Parameters:
- `ENTRIES`, default 3: number of station entries (2..8).
- `DATA_W`, default 32: operand and CDB data width.
- `TAG_W`, default 4: tag width. Tag 0 means "value present, no producer".
- `TAG_BASE`, default 1: tag of entry 0. Entry i has tag `TAG_BASE+i`, which must be nonzero and fit in `TAG_W`.

Ports:
- `clk`  in  1  single clock, rising edge.
- `nRST`  in  1  asynchronous active-low reset.
- `issueEN`  in  1  issue request; this station's bit of the control unit's `ResStationEN`.
- `ALUop`  in  2  operation code stored with the entry.
- `Vj`, `Vk`  in  DATA_W  operand values; valid only when the matching Q is 0.
- `Qj`, `Qk`  in  TAG_W  producer tags; 0 means the operand is ready.
- `issueTag`  out  TAG_W  tag the next issue will receive; written to register status by the issue logic.
- `isFull`  out  1  all entries busy.
- `CDBValid`  in  1  broadcast valid.
- `CDBTag`  in  TAG_W  broadcast tag.
- `CDBData`  in  DATA_W  broadcast value.
- `dispValid`  out  1  dispatch request to the functional unit.
- `aluReady`  in  1  functional unit accepts this cycle.
- `dispOp`  out  2  ALUop of the dispatched entry.
- `dispA`, `dispB`  out  DATA_W  Vj and Vk of the dispatched entry.
- `dispTag`  out  TAG_W  tag of the dispatched entry; the result is later broadcast on the CDB with this tag.

## Operation
- Per-entry state: `busy`, `op`, `Vj`, `Qj`, `Vk`, `Qk`.
- An entry is ready when `busy && Qj==0 && Qk==0`.
- Allocation: the lowest-index non-busy entry. `issueTag` is its tag, driven combinationally from registered state. When the station is full, `issueTag` shows entry 0's tag and is don't-care.
- Issue is accepted when `issueEN && !isFull`. `isFull` is evaluated on registered state.
  - If the station is full, the request is ignored.
  - An entry freed by dispatch in the same cycle does not make room for that cycle's issue.
- Issue bypass: if `CDBValid` is high and `CDBTag` equals a nonzero incoming `Qj`, the entry stores `Vj=CDBData` and `Qj=0` instead of the incoming values. `Qk` is handled the same way.
- Wakeup: for every busy entry with `Qx==CDBTag!=0` and `CDBValid` high, the entry latches `Vx=CDBData` and clears `Qx` at the clock edge. Both operands may wake in the same cycle.
- CDB tag 0 never matches.
- Dispatch selection: the lowest-index ready entry, unless a lock is held.
  - Lock: when `dispValid && !aluReady`, the selected index is registered and held until accepted. The `disp*` outputs must not change while waiting, even if a lower entry becomes ready.
- Accept: `dispValid && aluReady` at an edge clears that entry's `busy` and releases the lock.
- The station does not generate results. Entries are freed on dispatch, not on broadcast.

## Timing
- Reset (asynchronous, `nRST` low) forces:
  - all `busy`=0 and the lock cleared;
  - `isFull`=0, `dispValid`=0, `issueTag`=`TAG_BASE`;
  - `dispOp`, `dispA`, `dispB`, `dispTag` to 0.
- Reset takes effect immediately and mid-operation. Pending entries are discarded, and any `dispValid` drops in the same cycle.
- Issue at edge T with both operands ready: `dispValid`=1 in cycle T+1. An entry is never dispatchable in its own issue cycle.
- A CDB wakeup at edge T makes the entry ready in cycle T+1.
- One issue, one dispatch and one CDB broadcast may occur in the same cycle; all three take effect at the same edge.
- Accepted dispatch at edge T: the entry is free from cycle T+1. `isFull` deasserts in T+1 if the station was full.
- All outputs are combinational from registered state only. There is no combinational path from `issueEN`, the CDB inputs or `aluReady` to any output.

## Test plan
- Reset, then idle: `isFull`=0, `dispValid`=0, `issueTag`=1. Assert `nRST` low mid-dispatch: `dispValid` drops immediately.
- Issue op=1, Vj=5, Vk=7, Qj=Qk=0 -> next cycle `dispValid`=1, `dispA`=5, `dispB`=7, `dispTag`=1. With `aluReady`=1 -> entry freed and `issueTag` returns to 1.
- Issue with Qj=6, Vk=3. Two cycles later broadcast CDBTag=6, CDBData=0x1234 -> `dispValid` rises the following cycle with `dispA`=0x1234. A broadcast with tag 5 causes no change.
- Issue three instructions with pending tags -> `isFull`=1. A fourth `issueEN` is ignored and no entry changes. Dispatch one in the same cycle as a fifth issue -> the fifth is still ignored.
- Issue with Qk=9 in the same cycle as CDBTag=9, CDBData=0xAB -> stored Vk=0xAB, and the entry is dispatchable next cycle.
- Entry 2 ready with `aluReady`=0 for 3 cycles while entry 0 wakes -> `disp*` stays on tag 3. After accept, entry 0 dispatches next.
